// File: rtl/sd_stream_word_loader_pkg.sv
// Shared types and helpers for the SD stream word loader.
// Default load size comes from the build-wide BIN_SIZE define.
`ifndef BIN_SIZE
`define BIN_SIZE 4096
`endif

package sd_stream_word_loader_pkg;

  localparam int DEF_LOAD_SIZE = `BIN_SIZE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } ld_state_t;

  function automatic int lane_pos(
    input int lane,
    input int wb,
    input bit be
  );
    return be ? (wb - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/sd_stream_word_loader_fifo.sv
// Small synchronous word FIFO for the loader.
// A push into a full FIFO only succeeds alongside a pop.
module loader_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk27mhz,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  // Status flags and effective push/pop
  always_comb begin
    o_full  = (r_cnt == FULL_CNT);
    o_empty = (r_cnt == '0);
    w_pop   = i_pop && !o_empty;
    w_push  = i_push && (!o_full || w_pop);
    o_rdata = r_mem[r_rp];
    o_count = r_cnt;
  end

  // Pointers and occupancy
  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array
  always_ff @(posedge clk27mhz) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/sd_stream_word_loader.sv
// Packs SD reader bytes into words and writes them to memory
// at ascending addresses through a small FIFO.
module sd_stream_word_loader
  import sd_stream_word_loader_pkg::*;
#(
  parameter int          WORD_BYTES = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LOAD_SIZE  = DEF_LOAD_SIZE,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic                    clk27mhz,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  input  logic                    in_eof,
  output logic                    wr_req,
  output logic [31:0]             wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  input  logic                    wr_ack,
  output logic                    done,
  output logic                    overflow,
  output logic [31:0]             bytes_loaded
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);
  localparam logic [31:0]   LIMIT     = 32'(LOAD_SIZE);
  localparam logic [31:0]   STEP      = 32'(WORD_BYTES);

  ld_state_t     r_state;
  logic          r_done;
  logic [LW-1:0] r_lane;
  logic [W-1:0]  r_word;
  logic          r_pend;
  logic [W-1:0]  r_pend_data;
  logic [31:0]   r_bytes;
  logic [31:0]   r_addr;
  logic          r_req;
  logic          r_ovf;

  logic          w_fill;
  logic          w_acc;
  logic          w_eof;
  logic          w_last;
  logic          w_lane_end;
  logic [LW-1:0] w_lane_inc;
  logic [W-1:0]  w_word_nxt;
  int            w_pos;
  logic          w_cmp;
  logic          w_end;
  logic          w_pop;
  logic [W-1:0]  w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  // Byte acceptance, lane packing and word completion
  always_comb begin
    w_fill     = (r_state == S_FILL);
    w_acc      = w_fill && enable && in_valid && (r_bytes < LIMIT);
    w_eof      = w_fill && in_eof;
    w_last     = w_acc && ((r_bytes + 32'd1) == LIMIT);
    w_lane_end = (r_lane == LAST_LANE);
    w_lane_inc = w_lane_end ? '0 : r_lane + 1'b1;
    w_pos      = lane_pos(int'(r_lane), WORD_BYTES, BIG_ENDIAN);
    w_word_nxt = r_word;
    if (w_acc) w_word_nxt[8*w_pos +: 8] = in_byte;
    w_cmp = (w_acc && (w_lane_end || w_last))
         || (w_eof && (w_acc || (r_lane != '0)));
    w_end = w_eof || w_last;
    w_pop = r_req && wr_ack;
  end

  // Output port mapping
  always_comb begin
    wr_req       = r_req;
    wr_addr      = r_addr;
    wr_data      = r_req ? w_head : '0;
    done         = r_done;
    overflow     = r_ovf;
    bytes_loaded = r_bytes;
  end

  // Load sequencing and sticky completion flag
  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (enable) r_state <= S_FILL;
        S_FILL:
          if (w_end)        r_state <= S_DRAIN;
          else if (!enable) r_state <= S_IDLE;
        S_DRAIN:
          if (!r_pend && w_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        S_DONE:
          r_done <= 1'b1;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  // Word assembly; a finished word is staged for the next edge
  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      r_lane      <= '0;
      r_word      <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_bytes     <= '0;
    end else begin
      r_pend <= w_cmp;
      if (w_cmp) r_pend_data <= w_word_nxt;
      if (w_acc) r_bytes <= r_bytes + 32'd1;
      if (w_cmp) begin
        r_lane <= '0;
        r_word <= '0;
      end else if (w_acc) begin
        r_lane <= w_lane_inc;
        r_word <= w_word_nxt;
      end
    end
  end

  // Write request, address stepping and drop detection
  always_ff @(posedge clk27mhz) begin
    if (!resetn) begin
      r_req  <= 1'b0;
      r_addr <= BASE_ADDR;
      r_ovf  <= 1'b0;
    end else begin
      r_req <= ((w_count - CW'(w_pop)) != '0);
      if (w_pop) r_addr <= r_addr + STEP;
      if (r_pend && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  loader_word_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk27mhz (clk27mhz),
    .resetn   (resetn),
    .i_push   (r_pend),
    .i_pop    (w_pop),
    .i_wdata  (r_pend_data),
    .o_rdata  (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

endmodule

// File: tb/tb_sd_stream_word_loader.sv
// Bench for sd_stream_word_loader: three configurations driven
// by the same byte stream and checked against a word model.
module tb_sd_stream_word_loader;

  logic       clk27mhz = 1'b0;
  logic       resetn   = 1'b0;
  logic       enable   = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_eof   = 1'b0;
  logic       wr_ack   = 1'b0;
  logic [7:0] in_byte  = 8'h00;

  logic [2:0]       req;
  logic [2:0]       dn;
  logic [2:0]       ovf;
  logic [2:0][31:0] addr;
  logic [2:0][31:0] data;
  logic [2:0][31:0] nbytes;

  int npass    = 0;
  int ntot     = 0;
  int ack_mode = 0;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic [7:0] sent[$];
  wr_t        got[$];

  logic [2:0]       hold = '0;
  logic [2:0][31:0] h_a;
  logic [2:0][31:0] h_d;

  always #5 clk27mhz = ~clk27mhz;

  sd_stream_word_loader #(
    .WORD_BYTES(4), .FIFO_DEPTH(4), .LOAD_SIZE(64),
    .BASE_ADDR(32'h1000), .BIG_ENDIAN(1'b0)
  ) u_le (
    .clk27mhz(clk27mhz), .resetn(resetn), .enable(enable),
    .in_valid(in_valid), .in_byte(in_byte), .in_eof(in_eof),
    .wr_req(req[0]), .wr_addr(addr[0]), .wr_data(data[0]),
    .wr_ack(wr_ack), .done(dn[0]), .overflow(ovf[0]),
    .bytes_loaded(nbytes[0])
  );

  sd_stream_word_loader #(
    .WORD_BYTES(4), .FIFO_DEPTH(4), .LOAD_SIZE(64),
    .BASE_ADDR(32'h0), .BIG_ENDIAN(1'b1)
  ) u_be (
    .clk27mhz(clk27mhz), .resetn(resetn), .enable(enable),
    .in_valid(in_valid), .in_byte(in_byte), .in_eof(in_eof),
    .wr_req(req[1]), .wr_addr(addr[1]), .wr_data(data[1]),
    .wr_ack(wr_ack), .done(dn[1]), .overflow(ovf[1]),
    .bytes_loaded(nbytes[1])
  );

  sd_stream_word_loader #(
    .WORD_BYTES(4), .FIFO_DEPTH(4), .LOAD_SIZE(5),
    .BASE_ADDR(32'h2000), .BIG_ENDIAN(1'b0)
  ) u_ls5 (
    .clk27mhz(clk27mhz), .resetn(resetn), .enable(enable),
    .in_valid(in_valid), .in_byte(in_byte), .in_eof(in_eof),
    .wr_req(req[2]), .wr_addr(addr[2]), .wr_data(data[2]),
    .wr_ack(wr_ack), .done(dn[2]), .overflow(ovf[2]),
    .bytes_loaded(nbytes[2])
  );

  function automatic logic [31:0] base_of(input int k);
    case (k)
      0:       return 32'h1000;
      1:       return 32'h0000;
      default: return 32'h2000;
    endcase
  endfunction

  function automatic int ls_of(input int k);
    return (k == 2) ? 5 : 64;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Record handshakes and check stalled writes stay put
  always @(negedge clk27mhz) begin
    for (int k = 0; k < 3; k++) begin
      if (resetn && hold[k]) begin
        chk($sformatf("hold_req%0d", k), 32'(req[k]), 32'd1);
        chk($sformatf("hold_addr%0d", k), addr[k], h_a[k]);
        chk($sformatf("hold_data%0d", k), data[k], h_d[k]);
      end
      if (resetn && req[k] && wr_ack)
        got.push_back('{k, addr[k], data[k]});
      hold[k] <= resetn && req[k] && !wr_ack;
      h_a[k]  <= addr[k];
      h_d[k]  <= data[k];
    end
  end

  task automatic cyc();
    @(posedge clk27mhz);
    #1;
    case (ack_mode)
      0:       wr_ack = 1'b1;
      1:       wr_ack = ($urandom_range(3) != 0);
      default: wr_ack = 1'b0;
    endcase
  endtask

  function automatic logic [31:0] nth(input int k, input int i);
    int j;
    j = 0;
    nth = 'x;
    foreach (got[g]) begin
      if (got[g].k == k) begin
        if (j == i) nth = got[g].d;
        j++;
      end
    end
  endfunction

  task automatic do_reset();
    resetn   = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_eof   = 1'b0;
    ack_mode = 0;
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_req%0d", k), 32'(req[k]), 32'd0);
      chk($sformatf("rst_addr%0d", k), addr[k], base_of(k));
      chk($sformatf("rst_data%0d", k), data[k], 32'd0);
      chk($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd0);
      chk($sformatf("rst_ovf%0d", k), 32'(ovf[k]), 32'd0);
      chk($sformatf("rst_bytes%0d", k), nbytes[k], 32'd0);
    end
    resetn = 1'b1;
    got.delete();
    sent.delete();
    enable = 1'b1;
    cyc();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_byte  = b;
    sent.push_back(b);
    cyc();
    in_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  // A byte offered while enable is low must be ignored
  task automatic junk();
    enable   = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'($urandom);
    cyc();
    enable   = 1'b1;
    in_valid = 1'b0;
    cyc();
  endtask

  // Expected writes: bytes cut at the load size, grouped four
  // at a time, zero padded, at base + 4*index; with the write
  // port stalled only the first cap words survive.
  task automatic check_dut(input string tag, input int k, input int cap);
    int          n;
    int          nw;
    int          ne;
    int          j;
    bit          be;
    logic [31:0] w;
    be = (k == 1);
    n  = (sent.size() < ls_of(k)) ? sent.size() : ls_of(k);
    nw = (n + 3) / 4;
    ne = (cap > 0 && nw > cap) ? cap : nw;
    j  = 0;
    foreach (got[g]) begin
      if (got[g].k == k) begin
        if (j < ne) begin
          w = '0;
          for (int b = 0; b < 4; b++) begin
            if (4 * j + b < n) begin
              if (be) w[8*(3-b) +: 8] = sent[4*j+b];
              else    w[8*b +: 8]     = sent[4*j+b];
            end
          end
          chk($sformatf("%s_u%0d_addr%0d", tag, k, j),
              got[g].a, base_of(k) + 32'(4 * j));
          chk($sformatf("%s_u%0d_data%0d", tag, k, j), got[g].d, w);
        end
        j++;
      end
    end
    chk($sformatf("%s_u%0d_nwr", tag, k), 32'(j), 32'(ne));
    chk($sformatf("%s_u%0d_bytes", tag, k), nbytes[k], 32'(n));
    chk($sformatf("%s_u%0d_ovf", tag, k),
        32'(ovf[k]), 32'(cap > 0 && nw > cap));
    chk($sformatf("%s_u%0d_done", tag, k), 32'(dn[k]), 32'd1);
  endtask

  task automatic finish_load(input string tag, input int cap);
    in_eof = 1'b1;
    cyc();
    if (ack_mode == 2) begin
      repeat (10) cyc();
      ack_mode = 0;
    end
    for (int i = 0; i < 2000 && dn != 3'b111; i++) cyc();
    for (int k = 0; k < 3; k++) check_dut(tag, k, cap);
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(8'h11 * (i + 1)), 0);
    finish_load("A", 0);
    chk("A_le_w0", nth(0, 0), 32'h44332211);
    chk("A_le_w1", nth(0, 1), 32'h88776655);
    chk("A_ls5_w1", nth(2, 1), 32'h00000055);

    do_reset();
    ack_mode = 1;
    for (int i = 1; i <= 4; i++) send(8'(i), $urandom_range(1));
    finish_load("B", 0);
    chk("B_be_w0", nth(1, 0), 32'h01020304);

    do_reset();
    ack_mode = 1;
    for (int i = 0; i < 6; i++) send(8'(8'h11 * (i + 1)), 0);
    finish_load("C", 0);
    chk("C_le_w1", nth(0, 1), 32'h00006655);

    do_reset();
    ack_mode = 2;
    for (int i = 0; i < 24; i++) send(8'($urandom), 0);
    finish_load("D", 4);
    chk("D_le_ovf", 32'(ovf[0]), 32'd1);

    do_reset();
    for (int i = 1; i <= 12; i++) send(8'(i), 0);
    finish_load("E", 0);
    chk("E_ls5_w0", nth(2, 0), 32'h04030201);
    chk("E_ls5_w1", nth(2, 1), 32'h00000005);
    chk("E_ls5_bytes", nbytes[2], 32'd5);

    do_reset();
    for (int i = 1; i <= 12; i++) send(8'(i), 0);
    repeat (6) cyc();
    chk("F_le_notdone", 32'(dn[0]), 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    finish_load("F", 0);

    do_reset();
    finish_load("G", 0);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      ack_mode = 1;
      for (int i = 0; i < int'($urandom_range(40)); i++) begin
        if ($urandom_range(7) == 0) junk();
        send(8'($urandom), $urandom_range(2));
      end
      finish_load($sformatf("R%0d", r), 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
